perceptron_trainer: RTL and testbench
=====================================

Name: perceptron_trainer

Overview:
Training engine for the perceptron predictor. It runs when a branch resolves. It takes the resolved outcome, the y sum computed at predict time, the history and the table row, and decides whether training is needed. If so, it performs a pipelined read-modify-write of every weight in that row, with saturation. It sits between the branch-resolution path and the weight table, opposite the prediction path.

Parameters:
HIST_LEN, 32, global history length; a row holds HIST_LEN+1 weights, index 0 is the bias.
WEIGHT_WIDTH, 8, signed weight width.
NUM_ROWS, 256, number of weight-table rows.
Y_OUT_WIDTH, 16, signed width of the y sum.
THETA, 75, training threshold, floor(1.93*HIST_LEN+14).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
upd_valid  in  1  resolved-branch update request
upd_ready  out  1  trainer can accept an update
upd_y  in  Y_OUT_WIDTH  signed y captured at predict time
upd_taken  in  1  actual outcome (1 = taken)
upd_hist  in  HIST_LEN  history at predict time; bit i-1 feeds weight i
upd_row  in  clog2(NUM_ROWS)  weight-table row
upd_done  out  1  one-cycle pulse when the update completes
upd_trained  out  1  valid with upd_done; 1 if weights were written
wt_rd_en  out  1  weight read strobe
wt_rd_addr  out  clog2(NUM_ROWS)+clog2(HIST_LEN+1)  {row, weight index}
wt_rd_data  in  WEIGHT_WIDTH  read data, valid the cycle after wt_rd_en
wt_wr_en  out  1  weight write strobe
wt_wr_addr  out  same as wt_rd_addr  write address
wt_wr_data  out  WEIGHT_WIDTH  write data

Behaviour:
- Single clock domain (clk). rst is synchronous and active-high.
- Reset values: upd_ready=1; upd_done, upd_trained, wt_rd_en and wt_wr_en are 0; all addresses and data are 0.
- FSM states: IDLE, RUN, DONE.
- Acceptance: upd_valid && upd_ready in IDLE. On acceptance, upd_y, upd_taken, upd_hist and upd_row are registered. upd_ready is 1 only in IDLE.
- Predicted bit is recomputed internally as ~upd_y[MSB], i.e. taken iff y >= 0.
- abs_y is computed at Y_OUT_WIDTH+1 bits, so the most-negative y is handled exactly.
- Training condition: train = (pred != upd_taken) || (abs_y <= THETA).
- If train=0: IDLE -> DONE. The next cycle pulses upd_done=1 with upd_trained=0. No memory traffic.
- If train=1: IDLE -> RUN. Let cycle 1 be the first cycle after acceptance.
- RUN reads: in cycle k+1, for k = 0..HIST_LEN, wt_rd_en=1 and wt_rd_addr={row,k}.
- RUN writes: in cycle k+2, wt_wr_en=1, wt_wr_addr={row,k}, wt_wr_data=sat(wt_rd_data ± 1).
  - Bias (k=0): +1 if taken, else -1.
  - k >= 1: +1 if hist[k-1]==taken, else -1.
- Read and write overlap. The read address k never equals the write address k-1 in the same cycle, so there is no hazard.
- After the last write (cycle HIST_LEN+2), go to DONE. upd_done=1 and upd_trained=1 in cycle HIST_LEN+3.
- DONE -> IDLE. upd_ready=1 in the cycle after DONE. Busy period for a trained update: HIST_LEN+4 cycles from acceptance to ready.
- Saturation range is [-2^(WEIGHT_WIDTH-1), 2^(WEIGHT_WIDTH-1)-1]: +1 at max stays max, -1 at min stays min. No wrap.
- upd_valid while busy is ignored (ready=0). The requester holds the update.
- Reset mid-RUN: at that edge, go to IDLE with reset values; no further strobes. The partially updated row is accepted as-is.
- upd_done and upd_valid in the same cycle cannot accept, because ready=0 in DONE.

Decomposition:
- Shared package global_parameters: HIST_LEN, WEIGHT_WIDTH, NUM_ROWS, Y_OUT_WIDTH, THETA; typedefs weight_t (signed WEIGHT_WIDTH) and y_t (signed Y_OUT_WIDTH); derived ROW_IDX_W and WEIGHT_IDX_W.
- FSM state enum is local to the module.
- Sub-module weight_saturator: combinational weight_t in, inc/dec select, saturated weight_t out.

Test Plan:
- Confident correct: y=+100, taken=1 -> no training. upd_done=1, upd_trained=0 at cycle 1; wt_rd_en and wt_wr_en never assert.
- Mispredict: y=+100, taken=0, hist=all 1s, all weights=5 -> 33 writes, addresses 0..32 in order. Every weight becomes 4; upd_done at cycle 35.
- Low-confidence correct: y=-10, taken=0, hist=32'hAAAA_AAAA -> trains. Bias becomes 4; weights for hist bit 0 become 6, for hist bit 1 become 4.
- Threshold boundaries, all correct predictions:
  - y=+75, taken=1 -> trains.
  - y=+76, taken=1 -> does not train.
  - y=-32768, taken=0 -> does not train (abs width check).
- Saturation: weights 127 with increment -> stay 127. Weights -128 with decrement -> stay -128.
- Reset after the 10th write: no write in any later cycle; upd_ready=1 the cycle after reset. A new update then trains with full timing. upd_valid held during busy is accepted only when upd_ready=1.

Source files
------------

// File: rtl/perceptron_trainer_pkg.sv
// Shared sizing, types and helper functions for the perceptron predictor.
package global_parameters;

  localparam int HIST_LEN     = 32;
  localparam int WEIGHT_WIDTH = 8;
  localparam int NUM_ROWS     = 256;
  localparam int Y_OUT_WIDTH  = 16;
  localparam int THETA        = 75;

  localparam int ROW_IDX_W    = $clog2(NUM_ROWS);
  localparam int WEIGHT_IDX_W = $clog2(HIST_LEN + 1);
  localparam int WT_ADDR_W    = ROW_IDX_W + WEIGHT_IDX_W;

  typedef logic signed [WEIGHT_WIDTH-1:0] weight_t;
  typedef logic signed [Y_OUT_WIDTH-1:0]  y_t;

  // Direction for weight idx: 1 = increment, 0 = decrement.
  // Bias (idx 0) follows the outcome; weight i agrees when hist[i-1] matches it.
  function automatic logic weight_dir(input logic [WEIGHT_IDX_W-1:0] idx,
                                      input logic [HIST_LEN-1:0]     hist,
                                      input logic                    taken);
    logic [HIST_LEN-1:0] sh;
    logic                d;
    sh = hist >> (idx - WEIGHT_IDX_W'(1));
    if (idx == {WEIGHT_IDX_W{1'b0}}) begin
      d = taken;
    end else begin
      d = (sh[0] == taken);
    end
    return d;
  endfunction

endpackage

// File: rtl/perceptron_trainer_weight_saturator.sv
// Combinational +/-1 step on a signed weight, clamped to the weight range.
module weight_saturator
  import global_parameters::*;
(
  input  weight_t w_in,
  input  logic    inc,
  output weight_t w_out
);

  localparam weight_t W_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
  localparam weight_t W_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
  localparam weight_t W_ONE = {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1};

  // Step toward the requested direction, holding at the range limits.
  always_comb begin
    w_out = w_in;
    if (inc) begin
      if (w_in == W_MAX) begin
        w_out = W_MAX;
      end else begin
        w_out = w_in + W_ONE;
      end
    end else begin
      if (w_in == W_MIN) begin
        w_out = W_MIN;
      end else begin
        w_out = w_in - W_ONE;
      end
    end
  end

endmodule

// File: rtl/perceptron_trainer.sv
// Perceptron training engine: decides whether a resolved branch needs
// training and, if so, streams a read-modify-write over its weight row.
module perceptron_trainer
  import global_parameters::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [Y_OUT_WIDTH-1:0]  upd_y,
  input  logic                    upd_taken,
  input  logic [HIST_LEN-1:0]     upd_hist,
  input  logic [ROW_IDX_W-1:0]    upd_row,
  output logic                    upd_done,
  output logic                    upd_trained,
  output logic                    wt_rd_en,
  output logic [WT_ADDR_W-1:0]    wt_rd_addr,
  input  logic [WEIGHT_WIDTH-1:0] wt_rd_data,
  output logic                    wt_wr_en,
  output logic [WT_ADDR_W-1:0]    wt_wr_addr,
  output logic [WEIGHT_WIDTH-1:0] wt_wr_data
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [Y_OUT_WIDTH:0]    THETA_EXT = (Y_OUT_WIDTH+1)'(THETA);
  localparam logic [WEIGHT_IDX_W-1:0] LAST_IDX  = WEIGHT_IDX_W'(HIST_LEN);
  localparam logic [WEIGHT_IDX_W-1:0] IDX_ONE   = WEIGHT_IDX_W'(1);

  logic [1:0]              state_r;
  logic [HIST_LEN-1:0]     hist_r;
  logic                    taken_r;
  logic [ROW_IDX_W-1:0]    row_r;
  logic [WEIGHT_IDX_W-1:0] rd_idx_r;
  logic                    wr_inc_r;
  logic                    upd_ready_r;
  logic                    upd_done_r;
  logic                    upd_trained_r;
  logic                    rd_en_r;
  logic [WT_ADDR_W-1:0]    rd_addr_r;
  logic                    wr_en_r;
  logic [WT_ADDR_W-1:0]    wr_addr_r;

  logic                    pred_s;
  logic [Y_OUT_WIDTH:0]    y_ext_s;
  logic [Y_OUT_WIDTH:0]    abs_y_s;
  logic                    train_s;
  logic                    accept_s;
  weight_t                 sat_in_s;
  weight_t                 sat_out_s;

  // Training decision from the incoming request; abs taken one bit wider
  // so the most negative y does not overflow.
  always_comb begin
    pred_s  = ~upd_y[Y_OUT_WIDTH-1];
    y_ext_s = {upd_y[Y_OUT_WIDTH-1], upd_y};
    if (y_ext_s[Y_OUT_WIDTH]) begin
      abs_y_s = ~y_ext_s + {{Y_OUT_WIDTH{1'b0}}, 1'b1};
    end else begin
      abs_y_s = y_ext_s;
    end
    train_s  = (pred_s != upd_taken) || (abs_y_s <= THETA_EXT);
    accept_s = upd_valid && upd_ready_r;
  end

  assign sat_in_s = weight_t'(wt_rd_data);

  weight_saturator u_sat (
    .w_in  (sat_in_s),
    .inc   (wr_inc_r),
    .w_out (sat_out_s)
  );

  // Write data follows the read data of the same cycle; forced to zero
  // whenever no write is in flight.
  always_comb begin
    if (wr_en_r) begin
      wt_wr_data = sat_out_s;
    end else begin
      wt_wr_data = {WEIGHT_WIDTH{1'b0}};
    end
  end

  // Control FSM, read pointer and one-cycle-delayed write pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      hist_r        <= {HIST_LEN{1'b0}};
      taken_r       <= 1'b0;
      row_r         <= {ROW_IDX_W{1'b0}};
      rd_idx_r      <= {WEIGHT_IDX_W{1'b0}};
      wr_inc_r      <= 1'b0;
      upd_ready_r   <= 1'b1;
      upd_done_r    <= 1'b0;
      upd_trained_r <= 1'b0;
      rd_en_r       <= 1'b0;
      rd_addr_r     <= {WT_ADDR_W{1'b0}};
      wr_en_r       <= 1'b0;
      wr_addr_r     <= {WT_ADDR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            hist_r      <= upd_hist;
            taken_r     <= upd_taken;
            row_r       <= upd_row;
            upd_ready_r <= 1'b0;
            if (train_s) begin
              state_r   <= ST_RUN;
              rd_en_r   <= 1'b1;
              rd_idx_r  <= {WEIGHT_IDX_W{1'b0}};
              rd_addr_r <= {upd_row, {WEIGHT_IDX_W{1'b0}}};
            end else begin
              state_r       <= ST_DONE;
              upd_done_r    <= 1'b1;
              upd_trained_r <= 1'b0;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          wr_en_r   <= rd_en_r;
          wr_addr_r <= rd_addr_r;
          wr_inc_r  <= weight_dir(rd_idx_r, hist_r, taken_r);
          if (rd_en_r && (rd_idx_r != LAST_IDX)) begin
            rd_idx_r  <= rd_idx_r + IDX_ONE;
            rd_addr_r <= {row_r, rd_idx_r + IDX_ONE};
          end else begin
            rd_en_r <= 1'b0;
          end
          if (wr_en_r && !rd_en_r) begin
            state_r       <= ST_DONE;
            upd_done_r    <= 1'b1;
            upd_trained_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r       <= ST_IDLE;
          upd_done_r    <= 1'b0;
          upd_trained_r <= 1'b0;
          upd_ready_r   <= 1'b1;
        end
        default: begin
          state_r       <= ST_IDLE;
          upd_ready_r   <= 1'b1;
          upd_done_r    <= 1'b0;
          upd_trained_r <= 1'b0;
          rd_en_r       <= 1'b0;
          wr_en_r       <= 1'b0;
        end
      endcase
    end
  end

  assign upd_ready   = upd_ready_r;
  assign upd_done    = upd_done_r;
  assign upd_trained = upd_trained_r;
  assign wt_rd_en    = rd_en_r;
  assign wt_rd_addr  = rd_addr_r;
  assign wt_wr_en    = wr_en_r;
  assign wt_wr_addr  = wr_addr_r;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Scoreboard bench for perceptron_trainer with a behavioural weight table.
module tb_perceptron_trainer;

  logic        clk;
  logic        rst;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] upd_y;
  logic        upd_taken;
  logic [31:0] upd_hist;
  logic [7:0]  upd_row;
  logic        upd_done;
  logic        upd_trained;
  logic        wt_rd_en;
  logic [13:0] wt_rd_addr;
  logic [7:0]  wt_rd_data;
  logic        wt_wr_en;
  logic [13:0] wt_wr_addr;
  logic [7:0]  wt_wr_data;

  perceptron_trainer dut (
    .clk         (clk),
    .rst         (rst),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_y       (upd_y),
    .upd_taken   (upd_taken),
    .upd_hist    (upd_hist),
    .upd_row     (upd_row),
    .upd_done    (upd_done),
    .upd_trained (upd_trained),
    .wt_rd_en    (wt_rd_en),
    .wt_rd_addr  (wt_rd_addr),
    .wt_rd_data  (wt_rd_data),
    .wt_wr_en    (wt_wr_en),
    .wt_wr_addr  (wt_wr_addr),
    .wt_wr_data  (wt_wr_data)
  );

  typedef struct { logic [13:0] addr; logic [7:0] data; int cyc; } ev_t;
  typedef struct { logic trained; int cyc; } dn_t;

  ev_t rd_q[$];
  ev_t wr_q[$];
  dn_t dn_q[$];
  ev_t mon_e;
  dn_t mon_d;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_seen = 0;

  logic [7:0] mem [0:16383];
  logic       fill_en;
  logic [7:0] fill_row_v;
  logic [7:0] fill_val;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter: during a cycle, cyc equals the number of edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Weight table: one-cycle read latency, write on strobe, bulk row fill.
  always @(posedge clk) begin
    if (wt_rd_en) wt_rd_data <= mem[wt_rd_addr];
    if (wt_wr_en) mem[wt_wr_addr] <= wt_wr_data;
    if (fill_en) begin
      for (int k = 0; k < 33; k++) mem[{fill_row_v, 6'(k)}] <= fill_val;
    end
  end

  // Monitor: match every strobe/pulse against the scoreboard queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL rd_missing addr=%h due_cycle=%0d now=%0d", rd_q[0].addr, rd_q[0].cyc, cyc);
        void'(rd_q.pop_front());
      end
      if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL wr_missing addr=%h due_cycle=%0d now=%0d", wr_q[0].addr, wr_q[0].cyc, cyc);
        void'(wr_q.pop_front());
      end
      if (dn_q.size() > 0 && dn_q[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL done_missing due_cycle=%0d now=%0d", dn_q[0].cyc, cyc);
        void'(dn_q.pop_front());
      end
      if (wt_rd_en) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected addr=%h cycle=%0d required=no read", wt_rd_addr, cyc);
        end else begin
          mon_e = rd_q.pop_front();
          if (mon_e.addr !== wt_rd_addr || mon_e.cyc != cyc) begin
            errors++;
            $display("FAIL rd addr=%h cycle=%0d required addr=%h cycle=%0d", wt_rd_addr, cyc, mon_e.addr, mon_e.cyc);
          end
        end
      end
      if (wt_wr_en) begin
        checks++;
        wr_seen++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected addr=%h data=%0d cycle=%0d required=no write", wt_wr_addr, $signed(wt_wr_data), cyc);
        end else begin
          mon_e = wr_q.pop_front();
          if (mon_e.addr !== wt_wr_addr || mon_e.data !== wt_wr_data || mon_e.cyc != cyc) begin
            errors++;
            $display("FAIL wr addr=%h data=%0d cycle=%0d required addr=%h data=%0d cycle=%0d",
                     wt_wr_addr, $signed(wt_wr_data), cyc, mon_e.addr, $signed(mon_e.data), mon_e.cyc);
          end
        end
      end
      if (upd_done) begin
        checks++;
        if (dn_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected trained=%b cycle=%0d", upd_trained, cyc);
        end else begin
          mon_d = dn_q.pop_front();
          if (mon_d.trained !== upd_trained || mon_d.cyc != cyc) begin
            errors++;
            $display("FAIL done trained=%b cycle=%0d required trained=%b cycle=%0d", upd_trained, cyc, mon_d.trained, mon_d.cyc);
          end
        end
      end
    end
  end

  function automatic logic [7:0] ref_step(input logic [7:0] old, input logic inc);
    int v;
    v = int'($signed(old)) + (inc ? 1 : -1);
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return 8'(v);
  endfunction

  task automatic fill_row(input logic [7:0] row, input logic [7:0] val);
    @(negedge clk);
    fill_en = 1'b1; fill_row_v = row; fill_val = val;
    @(negedge clk);
    fill_en = 1'b0;
  endtask

  // Present an update, wait for ready, push expectations, return acceptance cycle.
  task automatic do_update(input logic [15:0] y, input logic tk, input logic [31:0] h,
                           input logic [7:0] row, input logic exp_train, output int acc);
    int n;
    ev_t e;
    dn_t d;
    logic inc;
    @(negedge clk);
    upd_valid = 1'b1; upd_y = y; upd_taken = tk; upd_hist = h; upd_row = row;
    n = 0;
    while (!upd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (!upd_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout ready=%b required=1", upd_ready);
      upd_valid = 1'b0;
      return;
    end
    if (exp_train) begin
      for (int k = 0; k < 33; k++) begin
        inc = (k == 0) ? tk : (h[k-1] == tk);
        e.addr = {row, 6'(k)}; e.data = 8'h00; e.cyc = acc + 1 + k;
        rd_q.push_back(e);
        e.data = ref_step(mem[{row, 6'(k)}], inc); e.cyc = acc + 2 + k;
        wr_q.push_back(e);
      end
      d.trained = 1'b1; d.cyc = acc + 35;
    end else begin
      d.trained = 1'b0; d.cyc = acc + 1;
    end
    dn_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((rd_q.size() + wr_q.size() + dn_q.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if ((rd_q.size() + wr_q.size() + dn_q.size()) != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout pending=%0d required=0", rd_q.size() + wr_q.size() + dn_q.size());
      rd_q.delete(); wr_q.delete(); dn_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  int a1, a2, base, n;

  initial begin
    rst = 1'b1; upd_valid = 1'b0; upd_y = 16'h0; upd_taken = 1'b0;
    upd_hist = 32'h0; upd_row = 8'h0; fill_en = 1'b0; fill_row_v = 8'h0; fill_val = 8'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {27'h0, upd_ready, upd_done, upd_trained, wt_rd_en, wt_wr_en}, 32'h10);
    chk("reset_rd_addr", {18'h0, wt_rd_addr}, 32'h0);
    chk("reset_wr", {10'h0, wt_wr_addr, wt_wr_data}, 32'h0);

    // Confident and correct: no training.
    do_update(16'd100, 1'b1, 32'h0, 8'd1, 1'b0, a1);
    upd_valid = 1'b0; drain();

    // Mispredict, all weights 5, history all ones: every weight drops to 4.
    fill_row(8'd2, 8'd5);
    do_update(16'd100, 1'b0, 32'hFFFF_FFFF, 8'd2, 1'b1, a1);
    upd_valid = 1'b0; drain();
    chk("misp_w0", {24'h0, mem[{8'd2, 6'd0}]}, 32'h4);
    chk("misp_w32", {24'h0, mem[{8'd2, 6'd32}]}, 32'h4);

    // Low-confidence correct not-taken with alternating history.
    fill_row(8'd4, 8'd5);
    do_update(16'hFFF6, 1'b0, 32'hAAAA_AAAA, 8'd4, 1'b1, a1);
    upd_valid = 1'b0; drain();
    chk("lowc_bias", {24'h0, mem[{8'd4, 6'd0}]}, 32'h4);
    chk("lowc_w1", {24'h0, mem[{8'd4, 6'd1}]}, 32'h6);
    chk("lowc_w2", {24'h0, mem[{8'd4, 6'd2}]}, 32'h4);

    // Threshold boundaries.
    fill_row(8'd5, 8'd0);
    do_update(16'd75, 1'b1, 32'h0, 8'd5, 1'b1, a1);
    upd_valid = 1'b0; drain();
    do_update(16'd76, 1'b1, 32'h0, 8'd5, 1'b0, a1);
    upd_valid = 1'b0; drain();
    do_update(16'h8000, 1'b0, 32'h0, 8'd5, 1'b0, a1);
    upd_valid = 1'b0; drain();

    // Saturation at both ends.
    fill_row(8'd6, 8'd127);
    do_update(16'hFFFB, 1'b1, 32'hFFFF_FFFF, 8'd6, 1'b1, a1);
    upd_valid = 1'b0; drain();
    chk("sat_max", {24'h0, mem[{8'd6, 6'd17}]}, 32'h7F);
    fill_row(8'd7, 8'h80);
    do_update(16'd5, 1'b0, 32'hFFFF_FFFF, 8'd7, 1'b1, a1);
    upd_valid = 1'b0; drain();
    chk("sat_min", {24'h0, mem[{8'd7, 6'd17}]}, 32'h80);

    // Reset right after the 10th write of a training pass.
    fill_row(8'd8, 8'd20);
    base = wr_seen;
    do_update(16'd100, 1'b0, 32'hFFFF_FFFF, 8'd8, 1'b1, a1);
    upd_valid = 1'b0;
    n = 0;
    while (wr_seen < base + 10 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_reached_10_writes", wr_seen - base, 32'd10);
    rst = 1'b1;
    rd_q.delete(); wr_q.delete(); dn_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'h0, upd_ready}, 32'h1);
    repeat (40) @(negedge clk);
    chk("rst_w9", {24'h0, mem[{8'd8, 6'd9}]}, 32'd19);
    chk("rst_w10", {24'h0, mem[{8'd8, 6'd10}]}, 32'd20);

    // New trained update after reset, then a second one held while busy.
    fill_row(8'd9, 8'd0);
    do_update(16'd0, 1'b1, 32'h0, 8'd9, 1'b1, a1);
    do_update(16'd200, 1'b1, 32'h0, 8'd9, 1'b0, a2);
    upd_valid = 1'b0; drain();
    chk("held_accept_gap", a2 - a1, 32'd36);
    chk("post_rst_bias", {24'h0, mem[{8'd9, 6'd0}]}, 32'h1);
    chk("post_rst_w5", {24'h0, mem[{8'd9, 6'd5}]}, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
